// File: rtl/serin_frame_ctrl.sv
// serin_frame_ctrl: sequences an external WIDTH-bit shift register to receive
// one serial frame (start=1, WIDTH data bits, stop=0). It enables the shift
// register for exactly the data bits, captures the parallel output on a good
// stop bit, and holds it until downstream takes it with a valid/ready handshake.
module serin_frame_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serIn,
  output logic             shEn,
  input  logic [WIDTH-1:0] PO,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             frameErr,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, STOP, HOLD} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid, r_frameErr, r_overrun;
  logic             w_cap, w_ferr, w_take;

  // Downstream takes the frame only while it is actually being offered.
  assign w_take = (r_state == HOLD) && r_valid && ready;

  // Next-state and shift-enable decode; shEn depends on state alone so the
  // start and stop bits never clock the external register.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    shEn       = 1'b0;
    w_cap      = 1'b0;
    w_ferr     = 1'b0;
    case (r_state)
      IDLE: begin
        if (serIn) begin
          w_next     = SHIFT;
          w_cnt_next = '0;
        end
      end
      SHIFT: begin
        shEn       = 1'b1;
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) w_next = STOP;
      end
      STOP: begin
        if (!serIn) begin
          w_cap  = 1'b1;
          w_next = HOLD;
        end else begin
          w_ferr = 1'b1;
          w_next = IDLE;
        end
      end
      HOLD: begin
        // A start bit on the leaving edge is not looked at; IDLE samples
        // from the following cycle.
        if (w_take) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State, counter and registered outputs; reset drops any partial or
  // pending frame so stale shift-register contents never reach dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_dout     <= '0;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_frameErr <= w_ferr;
      if (w_cap) begin
        r_dout  <= PO;
        r_valid <= 1'b1;
      end else if (w_take) begin
        r_valid <= 1'b0;
      end
      // Line activity while a frame is parked means those bits are lost.
      if ((r_state == HOLD) && serIn) r_overrun <= 1'b1;
    end
  end

  assign busy     = (r_state != IDLE);
  assign dout     = r_dout;
  assign valid    = r_valid;
  assign frameErr = r_frameErr;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_serin_frame_ctrl.sv
// Bench for serin_frame_ctrl: an external shift register driven by shEn, a
// frame-level reference model that assembles data straight from the serial
// line, a per-cycle compare, and literal expectations for the key scenarios.
module tb_serin_frame_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1, serIn = 1'b0, ready = 1'b0;
  logic         shEn, valid, busy, frameErr, overrun;
  logic [W-1:0] PO, dout;
  logic [W-1:0] sr = '0;

  always #5 clk = ~clk;

  // External shift register, MSB-first.
  always @(posedge clk) if (shEn) sr <= {sr[W-2:0], serIn};
  assign PO = sr;

  serin_frame_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .serIn(serIn), .shEn(shEn), .PO(PO), .dout(dout),
    .valid(valid), .ready(ready), .busy(busy), .frameErr(frameErr),
    .overrun(overrun)
  );

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;
  int c_sh = 0, c_v = 0, c_fe = 0, c_busy = 0;

  // Reference model: position within the frame counted from the start bit,
  // data gathered from the line itself (never from PO).
  int           m_pos = 0;
  bit           m_hold = 0, m_valid = 0, m_ferr = 0, m_ovr = 0;
  logic [W-1:0] m_dout = '0, m_acc = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit s, input bit r, input bit rs);
    if (rs) begin
      m_pos = 0; m_hold = 0; m_valid = 0; m_ferr = 0; m_ovr = 0; m_dout = '0;
    end else begin
      m_ferr = 0;
      if (m_hold) begin
        if (s) m_ovr = 1;
        if (r) begin m_hold = 0; m_valid = 0; end
      end else if (m_pos == 0) begin
        if (s) begin m_pos = 1; m_acc = '0; end
      end else if (m_pos <= W) begin
        m_acc = {m_acc[W-2:0], s};
        m_pos++;
      end else begin
        if (!s) begin m_dout = m_acc; m_valid = 1; m_hold = 1; end
        else m_ferr = 1;
        m_pos = 0;
      end
    end
  endtask

  // One clock: apply inputs, compare outputs at the falling edge, advance
  // the model with the inputs sampled at the rising edge.
  task automatic step(input bit s, input bit r, input bit rs);
    serIn = s; ready = r; rst = rs;
    @(negedge clk);
    if (chk_en) begin
      chk("shEn",     shEn,     (m_pos >= 1 && m_pos <= W));
      chk("busy",     busy,     (m_pos != 0 || m_hold));
      chk("valid",    valid,    m_valid);
      chk("dout",     dout,     m_dout);
      chk("frameErr", frameErr, m_ferr);
      chk("overrun",  overrun,  m_ovr);
      if (shEn)     c_sh++;
      if (valid)    c_v++;
      if (frameErr) c_fe++;
      if (busy)     c_busy++;
    end
    @(posedge clk);
    model_update(s, r, rs);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input bit stopb, input bit r);
    step(1'b1, r, 1'b0);
    for (int i = W - 1; i >= 0; i--) step(d[i], r, 1'b0);
    step(stopb, r, 1'b0);
  endtask

  initial begin
    int sh0, v0, fe0, b0;
    // Reset state
    step(0, 0, 1);
    chk_en = 1;
    step(0, 0, 1);
    chk("rst_busy", busy, 0);
    chk("rst_shEn", shEn, 0);
    chk("rst_valid", valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ferr", frameErr, 0);
    chk("rst_ovr", overrun, 0);
    step(0, 1, 0);

    // Good frame 1,0,1,0,0,1,0,1 -> 0xA5, ready held high
    sh0 = c_sh; v0 = c_v; fe0 = c_fe;
    send_frame(8'hA5, 0, 1);
    chk("good_dout", dout, 8'hA5);
    chk("good_valid", valid, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    chk("good_shcnt", c_sh - sh0, 8);
    chk("good_vcnt", c_v - v0, 1);
    chk("good_fecnt", c_fe - fe0, 0);

    // Bad stop bit
    v0 = c_v; fe0 = c_fe;
    send_frame(8'h5A, 1, 1);
    chk("bad_ferr", frameErr, 1);
    chk("bad_valid", valid, 0);
    chk("bad_dout", dout, 8'hA5);
    step(0, 1, 0);
    chk("bad_busy", busy, 0);
    step(0, 1, 0);
    chk("bad_fecnt", c_fe - fe0, 1);
    chk("bad_vcnt", c_v - v0, 0);

    // Backpressure with line activity during HOLD
    send_frame(8'h5A, 0, 0);
    v0 = c_v;
    for (int i = 0; i < 20; i++) step(1, 0, 0);
    chk("bp_vcnt", c_v - v0, 20);
    chk("bp_dout", dout, 8'h5A);
    chk("bp_ovr", overrun, 1);
    step(1, 1, 0);          // start bit on the leaving edge is ignored
    chk("bp_valid_fall", valid, 0);
    chk("bp_busy", busy, 0);
    step(0, 0, 0);
    chk("bp_no_start", busy, 0);
    chk("bp_ovr_sticky", overrun, 1);

    // Reset after 4 data bits, then a clean frame
    step(1, 1, 0);
    step(0, 1, 0); step(0, 1, 0); step(1, 1, 0); step(1, 1, 0);
    step(1, 1, 1);
    chk("mid_busy", busy, 0);
    chk("mid_shEn", shEn, 0);
    chk("mid_valid", valid, 0);
    chk("mid_ovr", overrun, 0);
    chk("mid_dout", dout, 0);
    step(0, 1, 0);
    send_frame(8'h3C, 0, 1);
    chk("mid_frame_dout", dout, 8'h3C);
    step(0, 1, 0);

    // Back-to-back frames
    v0 = c_v;
    send_frame(8'hA5, 0, 1);
    chk("b2b_dout1", dout, 8'hA5);
    step(0, 1, 0);
    send_frame(8'h3C, 0, 1);
    chk("b2b_dout2", dout, 8'h3C);
    step(0, 1, 0);
    chk("b2b_vcnt", c_v - v0, 2);

    // Idle line, ready toggling with nothing valid
    sh0 = c_sh; v0 = c_v; fe0 = c_fe; b0 = c_busy;
    for (int i = 0; i < 100; i++) step(0, i[0], 0);
    chk("idle_sh", c_sh - sh0, 0);
    chk("idle_busy", c_busy - b0, 0);
    chk("idle_v", c_v - v0, 0);
    chk("idle_fe", c_fe - fe0, 0);
    chk("idle_dout", dout, 8'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
